// File: rtl/pcgen_pkg.sv
// Shared types and constants for the fetch-PC generator.
// Build option: PCGEN_MISALIGN_CHECK_EN (see rtl/pcgen.sv).
package pcgen_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam u64 PC_RESET = 64'h8000_0000;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    u64   pc;
    u32   raw_instr;
    logic exc_misalign;
  } fetch_data_t;

endpackage

// File: rtl/pcgen_fetch_buf.sv
// Single-entry {pc, instr} holding register used while decode stalls.
module pcgen_fetch_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        full,
  output logic [63:0] pc,
  output logic [31:0] instr
);

  logic        full_q;
  logic [63:0] pc_q;
  logic [31:0] instr_q;

  // Capture on load, drop on clear; load takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (load) begin
      full_q  <= 1'b1;
      pc_q    <= load_pc;
      instr_q <= load_instr;
    end else if (clear) begin
      full_q  <= 1'b0;
    end
  end

  assign full  = full_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/pcgen.sv
// Fetch PC generator: owns the fetch PC, drives the ibus request, buffers one
// instruction under decode stall and discards responses made stale by a redirect.
// Build option: PCGEN_MISALIGN_CHECK_EN -- a misaligned fetch PC issues no request
// and instead presents a zero instruction flagged exc_misalign until redirected.
module pcgen
  import pcgen_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = PC_RESET,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] pend_pc_q;
  logic [63:0] pc_inc;
  logic        misalign;
  logic        buf_load;
  logic        buf_clear;
  logic        buf_full;
  logic [63:0] buf_pc;
  logic [31:0] buf_instr;

  // addr_ok carries no information here: the request is held until data_ok anyway.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp.addr_ok;

  assign pc_inc = pc_q + u64'(INSTR_BYTES);

`ifdef PCGEN_MISALIGN_CHECK_EN
  assign misalign = (state_q == StFetch) && (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Buffer the response when it arrives unaccepted; release it once consumed or redirected.
  assign buf_load  = (state_q == StFetch) && !misalign && iresp.data_ok &&
                     !redirect_valid && !out_ready;
  assign buf_clear = (state_q == StHold) && (redirect_valid || out_ready);

  pcgen_fetch_buf u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_pc    (pc_q),
    .load_instr (iresp.data),
    .full       (buf_full),
    .pc         (buf_pc),
    .instr      (buf_instr)
  );

  // Fetch FSM and architectural PC / pending redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (misalign) begin
            if (redirect_valid) pc_q <= redirect_pc;
          end else if (iresp.data_ok) begin
            if (redirect_valid) begin
              pc_q <= redirect_pc;
            end else if (out_ready) begin
              pc_q <= pc_inc;
            end else begin
              state_q <= StHold;
            end
          end else if (redirect_valid) begin
            // Request already on the bus: remember the target, drop its response.
            pend_pc_q <= redirect_pc;
            state_q   <= StDiscard;
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            state_q <= StFetch;
          end else if (out_ready) begin
            pc_q    <= pc_inc;
            state_q <= StFetch;
          end
        end
        StDiscard: begin
          if (iresp.data_ok) begin
            pc_q    <= redirect_valid ? redirect_pc : pend_pc_q;
            state_q <= StFetch;
          end else if (redirect_valid) begin
            pend_pc_q <= redirect_pc;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Bus request and output stream, decoded from state.
  always_comb begin
    ireq.valid         = 1'b0;
    ireq.addr          = pc_q;
    out_valid          = 1'b0;
    dataF.pc           = pc_q;
    dataF.raw_instr    = iresp.data;
    dataF.exc_misalign = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (misalign) begin
          out_valid          = 1'b1;
          dataF.raw_instr    = '0;
          dataF.exc_misalign = 1'b1;
        end else begin
          ireq.valid = 1'b1;
          out_valid  = iresp.data_ok && !redirect_valid;
        end
      end
      StHold: begin
        out_valid       = buf_full;
        dataF.pc        = buf_pc;
        dataF.raw_instr = buf_instr;
      end
      StDiscard: begin
        ireq.valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pcgen.sv
// Self-checking bench for pcgen: directed scenarios plus randomized bus latency,
// stalls and redirects checked against a transaction-level reference model.
module tb_pcgen;
  import pcgen_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  fetch_data_t dataF;

  pcgen dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dataF          (dataF)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: fetch PC, at most one instruction awaiting decode,
  // and whether the outstanding bus response belongs to an abandoned stream.
  logic [63:0] m_pc;
  fetch_data_t held[$];
  logic        m_stale;
  logic [63:0] m_target;

  // Bus responder latency state.
  int unsigned lat_left;
  int unsigned max_lat;

  // Snapshot of DUT outputs from the most recent cycle.
  logic        seen_rv;
  logic [63:0] seen_addr;
  logic        seen_ov;
  logic [63:0] seen_pc;
  logic        seen_exc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    iresp          = '0;
    @(negedge clk);
    reset = 1'b0;
    m_pc     = PC_RESET;
    held.delete();
    m_stale  = 1'b0;
    m_target = '0;
    lat_left = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic rv, input logic [63:0] rpc, input logic rdy,
                       input logic dok, input logic [31:0] data);
    logic        misal;
    logic        exp_rv;
    logic        exp_ov;
    logic [63:0] exp_addr;
    fetch_data_t exp_d;
    @(negedge clk);
    misal = 1'b0;
`ifdef PCGEN_MISALIGN_CHECK_EN
    misal = (m_pc[1:0] != 2'b00);
`endif
    exp_rv   = (held.size() == 0) && (m_stale || !misal);
    exp_addr = m_pc;
    if (!exp_rv) dok = 1'b0;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    iresp.addr_ok  = exp_rv;
    iresp.data_ok  = dok;
    iresp.data     = data;
    #1;
    exp_ov = 1'b0;
    exp_d  = '0;
    if (held.size() != 0) begin
      exp_ov = 1'b1;
      exp_d  = held[0];
      if (rv) begin
        held.delete();
        m_pc = rpc;
      end else if (rdy) begin
        held.delete();
        m_pc = m_pc + 64'd4;
      end
    end else if (m_stale) begin
      if (dok) begin
        m_stale = 1'b0;
        m_pc    = rv ? rpc : m_target;
      end else if (rv) begin
        m_target = rpc;
      end
    end else if (misal) begin
      exp_ov = 1'b1;
      exp_d  = '{pc: m_pc, raw_instr: 32'h0, exc_misalign: 1'b1};
      if (rv) m_pc = rpc;
    end else if (dok) begin
      if (rv) begin
        m_pc = rpc;
      end else begin
        exp_ov = 1'b1;
        exp_d  = '{pc: m_pc, raw_instr: data, exc_misalign: 1'b0};
        if (rdy) m_pc = m_pc + 64'd4;
        else held.push_back(exp_d);
      end
    end else if (rv) begin
      m_stale  = 1'b1;
      m_target = rpc;
    end
    if (exp_rv && dok) lat_left = $urandom_range(0, max_lat);
    else if (exp_rv && lat_left > 0) lat_left--;

    check_eq("req_valid", 64'(ireq.valid), 64'(exp_rv));
    if (exp_rv) check_eq("req_addr", ireq.addr, exp_addr);
    check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check_eq("out_pc", dataF.pc, exp_d.pc);
      check_eq("out_instr", 64'(dataF.raw_instr), 64'(exp_d.raw_instr));
      check_eq("out_exc", 64'(dataF.exc_misalign), 64'(exp_d.exc_misalign));
    end
    seen_rv   = ireq.valid;
    seen_addr = ireq.addr;
    seen_ov   = out_valid;
    seen_pc   = dataF.pc;
    seen_exc  = dataF.exc_misalign;
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 64'd4;
`ifdef PCGEN_MISALIGN_CHECK_EN
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
    return t;
  endfunction

  initial begin
    int unsigned cfg_lat[3] = '{0, 3, 2};
    int unsigned cfg_rd[3]  = '{5, 15, 30};
    int unsigned cfg_rdy[3] = '{90, 50, 70};
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    iresp          = '0;
    max_lat        = 0;

    // Reset state and back-to-back fetch.
    do_reset();
    #1;
    check_eq("rst_req_valid", 64'(ireq.valid), 64'd1);
    check_eq("rst_req_addr", ireq.addr, 64'h8000_0000);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h1111_0000);
    check_eq("t1_addr0", seen_addr, 64'h8000_0000);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h1111_0004);
    check_eq("t1_addr1", seen_addr, 64'h8000_0004);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h1111_0008);
    check_eq("t1_addr2", seen_addr, 64'h8000_0008);
    check_eq("t1_ov2", 64'(seen_ov), 64'd1);

    // Stall with one buffered instruction.
    do_reset();
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h2222_0000);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h2222_0004);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, 32'h0);
      check_eq("t2_hold_rv", 64'(seen_rv), 64'd0);
      check_eq("t2_hold_pc", seen_pc, 64'h8000_0004);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check_eq("t2_next_addr", seen_addr, 64'h8000_0008);

    // Redirect while the request is in flight: response dropped.
    cycle(1'b1, 64'h8000_1000, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h3333_0008);
    check_eq("t3_drop_ov", 64'(seen_ov), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check_eq("t3_new_addr", seen_addr, 64'h8000_1000);

    // Latest redirect wins while discarding.
    cycle(1'b1, 64'h8000_2000, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 64'h8000_3000, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h4444_1000);
    cycle(1'b0, '0, 1'b0, 1'b1, 32'h5555_3000);
    check_eq("t4_new_addr", seen_addr, 64'h8000_3000);

    // Redirect beats out_ready in the stalled state.
    cycle(1'b1, 64'h8000_4000, 1'b1, 1'b0, 32'h0);
    check_eq("t5_hold_pc", seen_pc, 64'h8000_3000);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check_eq("t5_new_addr", seen_addr, 64'h8000_4000);

    // 64-bit PC wraps silently.
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h6666_FFFC);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check_eq("wrap_addr", seen_addr, 64'h0);
    cycle(1'b1, 64'h8000_0000, 1'b1, 1'b1, 32'h0);

`ifdef PCGEN_MISALIGN_CHECK_EN
    // Misaligned target: no request, exception presented until redirected.
    cycle(1'b1, 64'h8000_0002, 1'b1, 1'b1, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
      check_eq("t6_rv", 64'(seen_rv), 64'd0);
      check_eq("t6_ov", 64'(seen_ov), 64'd1);
      check_eq("t6_exc", 64'(seen_exc), 64'd1);
      check_eq("t6_pc", seen_pc, 64'h8000_0002);
    end
    cycle(1'b1, 64'h8000_0010, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0, 32'h0);
    check_eq("t6_resume", seen_addr, 64'h8000_0010);
`endif

    // Randomized traffic under several latency / stall / redirect mixes.
    for (int c = 0; c < 3; c++) begin
      max_lat = cfg_lat[c];
      do_reset();
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 249) == 0) do_reset();
        cycle($urandom_range(0, 99) < cfg_rd[c], rand_target(),
              $urandom_range(0, 99) < cfg_rdy[c], lat_left == 0, $urandom());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
